// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: 4-digit BCD countdown timer with a timebase prescaler.
// Ports:
//   clk         - clock, rising edge active
//   reset       - synchronous active-high reset
//   timebase    - single-cycle time base event (1 ms nominal)
//   counter_clr - level-sensitive reload of PRESET, clears the prescaler
//   counter_en  - level-sensitive count-down enable
//   counter_z   - high while the count value is zero
//   bcd         - current value, digit 3 in [15:12], digit 0 in [3:0]
//   status      - 0=LOADED, 1=RUNNING, 2=PAUSED, 3=EXPIRED
// Optional feature macro: BCD_TIMER_AUTORELOAD_EN (reload PRESET after expiry
// while enabled). Default build: saturate at zero.

module bcd_countdown_timer #(
    parameter logic [15:0] PRESET = 16'h3000,
    parameter int          TB_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timebase,
    input  logic        counter_clr,
    input  logic        counter_en,
    output logic        counter_z,
    output logic [15:0] bcd,
    output logic [1:0]  status
);

    localparam int PW = $clog2(TB_DIV + 1);
    localparam logic [PW-1:0] LAST = PW'(TB_DIV - 1);

    typedef enum logic [1:0] {
        LOADED  = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam state_t INIT = (PRESET == 16'h0000) ? EXPIRED : LOADED;

    state_t        state;
    logic [PW-1:0] presc;
    logic [15:0]   bcd_dec;
    logic          borrow;
    logic          step;
    logic          tick;

    // The prescaler only advances while enabled, not clearing, and nonzero,
    // so at zero it stays parked at 0 and no tick can underflow the value.
    assign step = counter_en && !counter_clr && (bcd != 16'h0000) && timebase;
    assign tick = step && (presc == LAST);

    assign counter_z = (bcd == 16'h0000);
    assign status    = state;

    // Ripple-borrow BCD decrement: a zero digit becomes 9 and passes the
    // borrow upward; the first nonzero digit absorbs it.
    always_comb begin
        bcd_dec = bcd;
        borrow  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (bcd[4*i +: 4] == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || counter_clr) begin
            bcd   <= PRESET;
            presc <= '0;
            state <= INIT;
        end
`ifdef BCD_TIMER_AUTORELOAD_EN
        else if (state == EXPIRED && counter_en) begin
            // One cycle at zero, then start the next period.
            bcd   <= PRESET;
            presc <= '0;
            state <= RUNNING;
        end
`endif
        else begin
            if (step) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            if (tick) begin
                bcd <= bcd_dec;
            end
            if (tick && bcd_dec == 16'h0000) begin
                state <= EXPIRED;
            end else begin
                case (state)
                    LOADED:  state <= counter_en ? RUNNING : LOADED;
                    RUNNING: state <= counter_en ? RUNNING : PAUSED;
                    PAUSED:  state <= counter_en ? RUNNING : PAUSED;
                    EXPIRED: state <= EXPIRED;
                    default: state <= LOADED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: scoreboard bench for bcd_countdown_timer.
// Three instances with different PRESET/TB_DIV share one stimulus stream.

module tb_bcd_countdown_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic clr   = 1'b0;
    logic en    = 1'b0;
    logic tb    = 1'b0;

    logic [15:0] bcd_o [3];
    logic [1:0]  st_o  [3];
    logic        z_o   [3];

    bcd_countdown_timer #(.PRESET(16'h0012), .TB_DIV(2)) u0 (
        .clk(clk), .reset(reset), .timebase(tb), .counter_clr(clr),
        .counter_en(en), .counter_z(z_o[0]), .bcd(bcd_o[0]), .status(st_o[0])
    );
    bcd_countdown_timer #(.PRESET(16'h1000), .TB_DIV(1)) u1 (
        .clk(clk), .reset(reset), .timebase(tb), .counter_clr(clr),
        .counter_en(en), .counter_z(z_o[1]), .bcd(bcd_o[1]), .status(st_o[1])
    );
    bcd_countdown_timer #(.PRESET(16'h0012), .TB_DIV(4)) u2 (
        .clk(clk), .reset(reset), .timebase(tb), .counter_clr(clr),
        .counter_en(en), .counter_z(z_o[2]), .bcd(bcd_o[2]), .status(st_o[2])
    );

    typedef struct {
        int v;
        int p;
        int s;
    } mdl_t;

    typedef struct {
        logic [15:0] b [3];
        logic [1:0]  s [3];
    } exp_t;

    mdl_t m [3];
    exp_t q [$];
    int   errs   = 0;
    int   checks = 0;

    function automatic int pval(int i);
        case (i)
            0:       return 12;
            1:       return 1000;
            default: return 12;
        endcase
    endfunction

    function automatic int dval(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Integer reference model of one timer.
    function automatic mdl_t model(mdl_t c, int pre, int div,
                                   logic r, logic k, logic e, logic t);
        mdl_t n;
        bit   tk;
        n  = c;
        tk = 1'b0;
        if (r || k) begin
            n.v = pre;
            n.p = 0;
            n.s = (pre == 0) ? 3 : 0;
            return n;
        end
`ifdef BCD_TIMER_AUTORELOAD_EN
        if (c.s == 3 && e) begin
            n.v = pre;
            n.p = 0;
            n.s = 1;
            return n;
        end
`endif
        if (e && t && c.v != 0) begin
            if (c.p == div - 1) begin
                n.p = 0;
                n.v = c.v - 1;
                tk  = 1'b1;
            end else begin
                n.p = c.p + 1;
            end
        end
        if (tk && n.v == 0) n.s = 3;
        else if (c.s == 0 && e) n.s = 1;
        else if (c.s == 1 && !e) n.s = 2;
        else if (c.s == 2 && e) n.s = 1;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic k, input logic e,
                       input logic t);
        exp_t x;
        reset = r;
        clr   = k;
        en    = e;
        tb    = t;
        for (int i = 0; i < 3; i++) begin
            m[i]   = model(m[i], pval(i), dval(i), r, k, e, t);
            x.b[i] = to_bcd(m[i].v);
            x.s[i] = 2'(m[i].s);
        end
        q.push_back(x);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            x = q.pop_front();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bcd%0d", i), 32'(bcd_o[i]), 32'(x.b[i]));
                check($sformatf("st%0d", i), 32'(st_o[i]), 32'(x.s[i]));
                check($sformatf("z%0d", i), 32'(z_o[i]),
                      32'(x.b[i] == 16'h0000));
            end
        end
    endtask

    task automatic ev(input logic e, input int n);
        for (int j = 0; j < n; j++) begin
            cyc(1'b0, 1'b0, e, 1'b1);
            cyc(1'b0, 1'b0, e, 1'b0);
            cyc(1'b0, 1'b0, e, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m[i] = '{v: 0, p: 0, s: 0};

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_bcd", 32'(bcd_o[0]), 32'h0012);
        check("rst_st", 32'(st_o[0]), 32'd0);
        check("rst_z", 32'(z_o[0]), 32'd0);
        check("rst_bcd1", 32'(bcd_o[1]), 32'h1000);

        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("borrow3", 32'(bcd_o[1]), 32'h0999);
        check("run_st", 32'(st_o[0]), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        ev(1'b1, 22);
        check("one_left", 32'(bcd_o[0]), 32'h0001);
        ev(1'b1, 1);
        check("zero_bcd", 32'(bcd_o[0]), 32'h0000);
        check("zero_z", 32'(z_o[0]), 32'd1);
`ifndef BCD_TIMER_AUTORELOAD_EN
        check("zero_st", 32'(st_o[0]), 32'd3);
        ev(1'b1, 20);
        check("sat_bcd", 32'(bcd_o[0]), 32'h0000);
        check("sat_z", 32'(z_o[0]), 32'd1);
        check("sat_st", 32'(st_o[0]), 32'd3);
`else
        ev(1'b1, 20);
`endif

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ev(1'b1, 3);
        check("frac_bcd", 32'(bcd_o[2]), 32'h0012);
        check("frac_run", 32'(st_o[2]), 32'd1);
        ev(1'b0, 10);
        check("pause_bcd", 32'(bcd_o[2]), 32'h0012);
        check("pause_st", 32'(st_o[2]), 32'd2);
        ev(1'b1, 1);
        check("resume_bcd", 32'(bcd_o[2]), 32'h0011);
        check("resume_st", 32'(st_o[2]), 32'd1);

        ev(1'b1, 10);
        check("at5_bcd", 32'(bcd_o[0]), 32'h0005);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_bcd", 32'(bcd_o[0]), 32'h0012);
        check("clr_st", 32'(st_o[0]), 32'd0);
        ev(1'b1, 1);
        check("clr_presc", 32'(bcd_o[0]), 32'h0012);
        ev(1'b1, 1);
        check("clr_tick", 32'(bcd_o[0]), 32'h0011);

        ev(1'b1, 8);
        check("at7_bcd", 32'(bcd_o[0]), 32'h0007);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        check("abort_bcd", 32'(bcd_o[0]), 32'h0012);
        check("abort_st", 32'(st_o[0]), 32'd0);
        check("abort_z", 32'(z_o[0]), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter PRESET, default 16'h3000, 4-digit BCD load value (d3 d2 . d1 d0 seconds); SHALL be valid BCD.
REQ-002 Parameter TB_DIV, default 10, timebase events per count tick (1 ms timebase -> 10 ms resolution); range 1..1023.
REQ-003 clk  input  1  clock, rising edge active.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 timebase  input  1  single-cycle time base event, 1 ms nominal.
REQ-006 counter_clr  input  1  reload PRESET, clear prescaler; level-sensitive.
REQ-007 counter_en  input  1  count-down enable; level-sensitive.
REQ-008 counter_z  output  1  value is zero.
REQ-009 bcd  output  16  current value, digit 3 in [15:12], digit 0 in [3:0].
REQ-010 status  output  2  0=LOADED, 1=RUNNING, 2=PAUSED, 3=EXPIRED.

Function
REQ-011 Prescaler (wordlength(TB_DIV) bits) SHALL increment on timebase only while counter_en=1, counter_clr=0 and value nonzero; at TB_DIV-1 it SHALL wrap to 0 and issue one tick.
REQ-012 Each tick SHALL decrement bcd by 1 in BCD: a digit at 0 becomes 9 and borrows from the next higher digit; digits never hold A-F.
REQ-013 bcd SHALL update in the clock cycle after the tick-producing timebase (1-cycle latency); counter_z SHALL be combinational from the bcd register (bcd==0).
REQ-014 At zero, bcd SHALL saturate: no ticks, no underflow, prescaler held at 0.
REQ-015 counter_en=0 SHALL freeze bcd and the prescaler; a resumed count SHALL continue with the stored prescaler fraction.
REQ-016 Priority: reset > counter_clr > tick; counter_clr with counter_en=1 and timebase=1 SHALL load PRESET, prescaler 0, no tick.
REQ-017 State LOADED -> RUNNING when counter_en=1; RUNNING -> PAUSED when counter_en=0; PAUSED -> RUNNING when counter_en=1.
REQ-018 RUNNING -> EXPIRED in the same cycle bcd becomes 0; EXPIRED holds until counter_clr or reset.
REQ-019 counter_clr from any state -> LOADED (EXPIRED if PRESET==0), taking effect next cycle.
REQ-020 Unreachable status encodings SHALL not occur; any illegal internal state SHALL recover to LOADED on the next cycle.

Reset
REQ-021 On reset: bcd=PRESET, prescaler=0, status=LOADED (EXPIRED if PRESET==0), counter_z=(PRESET==0).
REQ-022 Reset asserted mid-count SHALL abort the count without any further tick.

Configuration
REQ-023 Macro BCD_TIMER_AUTORELOAD_EN: when defined, in EXPIRED with counter_en=1 the block SHALL reload PRESET and prescaler 0 one cycle after reaching zero and return to RUNNING, so counter_z is a 1-cycle pulse; with counter_en=0, it SHALL remain EXPIRED at zero until counter_en=1 or counter_clr.
REQ-024 When BCD_TIMER_AUTORELOAD_EN is undefined, REQ-014/REQ-018 saturation SHALL apply unconditionally and no reload logic SHALL be synthesised.

Verification
REQ-025 PRESET=16'h0012, TB_DIV=2, en=1, timebase every 3 clks -> bcd 0012,0011,0010,0009 ... 0000 after 24 timebase events; counter_z rises with bcd=0000; status 1 then 3.
REQ-026 PRESET=16'h1000, TB_DIV=1, en=1, one timebase -> bcd=16'h0999 next cycle (triple borrow).
REQ-027 TB_DIV=4, en=1 for 3 timebase events, en=0 for 10 events, en=1 for 1 event -> exactly one tick, status 1->2->1.
REQ-028 counter_clr, counter_en and timebase high in the same cycle at bcd=16'h0005 -> bcd=PRESET, prescaler 0, status LOADED, no tick.
REQ-029 Value at 0000, en=1, further 20 timebase events -> bcd stays 0000, counter_z=1, status EXPIRED (macro undefined); macro defined -> counter_z high exactly 1 cycle, then bcd=PRESET, status RUNNING.
REQ-030 Reset asserted mid-count at bcd=16'h0007 -> next cycle bcd=PRESET, status LOADED, counter_z=0 (PRESET nonzero).
